// File: rtl/fp_div_result_stage.sv
// Issue/retire wrapper around fp_div: holds operands for LATENCY cycles, then applies IEEE-754 overrides.
// Build option: define FP_DIV_STATUS_EN to add the out_flags status port.
module fp_div_result_stage #(
  parameter int LATENCY = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_num1,
  output logic [31:0] div_num2,
  input  logic [31:0] div_s,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FP_DIV_STATUS_EN
  output logic [3:0]  out_flags,
`endif
  output logic [31:0] out_q
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic             sign_q,    sign_d;
  logic             nanCase_q, nanCase_d;
  logic             infCase_q, infCase_d;
  logic             zeroCase_q, zeroCase_d;
  logic signed [9:0] ext_q,    ext_d;

  logic [7:0]       expA, expB;
  logic             zeroA, zeroB, infA, infB, nanA, nanB;
  logic [7:0]       sExp;
  logic             ovfHit, unfHit;
  logic [31:0]      result_d;
  logic             capture;

  // Operand classification; denormals count as zero.
  always_comb begin
    expA       = in_a[30:23];
    expB       = in_b[30:23];
    zeroA      = (expA == 8'h00);
    zeroB      = (expB == 8'h00);
    infA       = (expA == 8'hFF) && (in_a[22:0] == 23'h0);
    infB       = (expB == 8'hFF) && (in_b[22:0] == 23'h0);
    nanA       = (expA == 8'hFF) && (in_a[22:0] != 23'h0);
    nanB       = (expB == 8'hFF) && (in_b[22:0] != 23'h0);
    sign_d     = in_a[31] ^ in_b[31];
    nanCase_d  = nanA | nanB | (zeroA & zeroB) | (infA & infB);
    infCase_d  = infA | zeroB;
    zeroCase_d = zeroA | infB;
    ext_d      = $signed({2'b00, expA}) - $signed({2'b00, expB}) + 10'sd127;
  end

  // fp_div may leave the exponent at ext or ext-1, so both ext and the delivered exponent are examined.
  always_comb begin
    sExp     = div_s[30:23];
    ovfHit   = (ext_q > 10'sd255) || ((ext_q == 10'sd255) && (sExp == 8'hFF));
    unfHit   = (ext_q < 10'sd1) || (sExp == 8'h00);
    result_d = div_s;
    if (nanCase_q) begin
      result_d = 32'h7FC00000;
    end else if (infCase_q) begin
      result_d = {sign_q, 8'hFF, 23'h0};
    end else if (zeroCase_q) begin
      result_d = {sign_q, 31'h0};
    end else if (ovfHit) begin
      result_d = {sign_q, 8'hFF, 23'h0};
    end else if (unfHit) begin
      result_d = {sign_q, 31'h0};
    end
  end

  assign capture = (state_q == BUSY) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_q      <= 32'h0;
      div_num1   <= 32'h0;
      div_num2   <= 32'h0;
      sign_q     <= 1'b0;
      nanCase_q  <= 1'b0;
      infCase_q  <= 1'b0;
      zeroCase_q <= 1'b0;
      ext_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            div_num2   <= in_a;
            div_num1   <= in_b;
            sign_q     <= sign_d;
            nanCase_q  <= nanCase_d;
            infCase_q  <= infCase_d;
            zeroCase_q <= zeroCase_d;
            ext_q      <= ext_d;
            cnt_q      <= CNT_LOAD;
            in_ready   <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (capture) begin
            out_q     <= result_d;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP_DIV_STATUS_EN
  logic divZero_q;
  logic [3:0] flags_d;

  // Flag priority mirrors the result override order; div_by_zero is independent of it.
  always_comb begin
    flags_d    = 4'b0000;
    flags_d[2] = divZero_q;
    if (nanCase_q) begin
      flags_d[3] = 1'b1;
    end else if (!infCase_q && !zeroCase_q) begin
      if (ovfHit) begin
        flags_d[1] = 1'b1;
      end else if (unfHit) begin
        flags_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      divZero_q <= 1'b0;
      out_flags <= 4'b0000;
    end else begin
      if ((state_q == IDLE) && in_valid) begin
        divZero_q <= zeroB & ~zeroA & ~nanA & ~nanB;
      end
      if (capture) begin
        out_flags <= flags_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_result_stage.sv
// Scoreboard bench for fp_div_result_stage with a latency-accurate stand-in for fp_div.
module tb_fp_div_result_stage;

  localparam int LAT = 26;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic [31:0] div_num1;
  logic [31:0] div_num2;
  logic [31:0] div_s;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_q;
`ifdef FP_DIV_STATUS_EN
  logic [3:0]  out_flags;
`endif

  always #5 clk = ~clk;

  fp_div_result_stage #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_num1  (div_num1),
    .div_num2  (div_num2),
    .div_s     (div_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP_DIV_STATUS_EN
    .out_flags (out_flags),
`endif
    .out_q     (out_q)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [3:0]  fl;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] curRaw = 32'h0;
  int          age = 0;

  // fp_div stand-in: S is garbage until LAT-1 edges after accept, so an early capture is visible.
  assign div_s = (age >= LAT - 1) ? curRaw : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (in_valid && in_ready) age <= 0;
    else if (age < 10000) age <= age + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: got 0x%08h, expected no output", out_q);
      end else begin
        monE = expQ.pop_front();
        checkOutput("out_q", out_q, monE.q);
`ifdef FP_DIV_STATUS_EN
        checkOutput("out_flags", {28'h0, out_flags}, {28'h0, monE.fl});
`endif
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] raw, input logic [31:0] q, input logic [3:0] fl);
    int n;
    bit ok;
    in_a = a;
    in_b = b;
    curRaw = raw;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_accept_timeout: got in_ready=0, expected 1", name);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expQ.push_back('{q: q, fl: fl});
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    // n counts edges after the accept edge; the accept edge itself makes LAT+1.
    checkOutput({name, "_latency"}, 32'(n + 1), 32'(LAT + 1));
    checkOutput({name, "_div_num1"}, div_num1, b);
    checkOutput({name, "_div_num2"}, div_num2, a);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("reset_out_q", out_q, 32'h0);
    checkOutput("reset_div_num1", div_num1, 32'h0);
    checkOutput("reset_div_num2", div_num2, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    //             name         a             b             raw           q             flags
    applyStimulus("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000);
    applyStimulus("one_by_0",   32'h3F800000, 32'h00000000, 32'h12345678, 32'h7F800000, 4'b0100);
    applyStimulus("zero_by_0",  32'h00000000, 32'h00000000, 32'h12345678, 32'h7FC00000, 4'b1000);
    applyStimulus("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h12345678, 32'h7FC00000, 4'b1000);
    applyStimulus("overflow",   32'h7F000000, 32'h00800000, 32'h3F800000, 32'h7F800000, 4'b0010);
    applyStimulus("underflow",  32'h00800000, 32'h7F000000, 32'h3F800000, 32'h00000000, 4'b0001);
    applyStimulus("neg6_by_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 4'b0000);
    applyStimulus("neg1_by_0",  32'hBF800000, 32'h00000000, 32'h12345678, 32'hFF800000, 4'b0100);
    applyStimulus("nan_by_1",   32'h7FC00001, 32'h3F800000, 32'h12345678, 32'h7FC00000, 4'b1000);
    applyStimulus("one_by_ninf",32'h3F800000, 32'hFF800000, 32'h12345678, 32'h80000000, 4'b0000);
    applyStimulus("inf_by_2",   32'h7F800000, 32'h40000000, 32'h12345678, 32'h7F800000, 4'b0000);
    applyStimulus("denorm_a",   32'h00000001, 32'h3F800000, 32'h12345678, 32'h00000000, 4'b0000);
    applyStimulus("ext255_ff",  32'h7F000000, 32'h3F000000, 32'h7F800001, 32'h7F800000, 4'b0010);
    applyStimulus("ext255_fe",  32'h7F000000, 32'h3F7FFFFF, 32'h7F000001, 32'h7F000001, 4'b0000);
    applyStimulus("ext256",     32'h7F000000, 32'h3E800000, 32'h3F800000, 32'h7F800000, 4'b0010);
    applyStimulus("ext1_exp0",  32'h00800000, 32'h3FFFFFFF, 32'h00400000, 32'h00000000, 4'b0001);
    applyStimulus("ext1_pass",  32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 4'b0000);
    applyStimulus("ext0",       32'h00800000, 32'h40000000, 32'h00800000, 32'h00000000, 4'b0001);

    // Backpressure: result must hold for 10 clocks while a competing operand is ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus("backpressure", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000);
    @(posedge clk);
    #1;
    in_a = 32'h3F800000;
    in_b = 32'h3F800000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'h0, out_valid}, 32'd1);
      checkOutput("bp_out_q", out_q, 32'h40400000);
      checkOutput("bp_in_ready", {31'h0, in_ready}, 32'd0);
      checkOutput("bp_div_num2", div_num2, 32'h40C00000);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_idle_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("bp_idle_out_valid", {31'h0, out_valid}, 32'd0);

    // Reset in the middle of BUSY aborts the division without retiring it.
    in_a = 32'h40C00000;
    in_b = 32'h40000000;
    curRaw = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("abort_out_valid", {31'h0, out_valid}, 32'd0);
    checkOutput("abort_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("abort_div_num1", div_num1, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus("after_reset", 32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 4'b0000);

    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
